// File: rtl/serv_pkg.sv
// Shared constants for the parametrised serv state controller: counter width,
// legal datapath widths and the beats-per-phase helper.
package serv_pkg;

    localparam int CNT_W   = 5;
    localparam int W_NARROW = 1;
    localparam int W_WIDE   = 4;

    function automatic int beats(input int w);
        return 32 / w;
    endfunction

endpackage

// File: rtl/serv_state_cnt.sv
// Operand-position counter: one phase of 32/W beats started by i_rf_ready, with
// a registered last-beat flag and position decodes gated by the count enable.
module serv_state_cnt
    import serv_pkg::*;
#(
    parameter int W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rf_ready,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt_en,
    output logic             o_cnt_done,
    output logic             o_cnt0,
    output logic             o_cnt1,
    output logic             o_cnt2,
    output logic             o_cnt3,
    output logic             o_cnt7,
    output logic             o_cnt0to3,
    output logic             o_cnt12to31,
    output logic [1:0]       o_mem_bytecnt
);

    localparam logic [CNT_W-1:0] STEP     = CNT_W'(W);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((beats(W) - 2) * W);
    localparam logic [CNT_W-1:0] BEAT7    = (W == W_WIDE) ? CNT_W'(4) : CNT_W'(7);

    logic [CNT_W-1:0] r_cnt;
    logic             r_cnt_en;
    logic             r_cnt_done;

    // Done is registered one beat early so it is high exactly on the last beat.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_cnt_en   <= 1'b0;
            r_cnt_done <= 1'b0;
        end else begin
            if (r_cnt_en)
                r_cnt <= r_cnt + STEP;
            r_cnt_en   <= r_cnt_en ? !r_cnt_done : i_rf_ready;
            r_cnt_done <= r_cnt_en && (r_cnt == PRE_LAST);
        end
    end

    logic w_cnt0;
    assign w_cnt0 = r_cnt_en && (r_cnt == '0);

    assign o_cnt         = r_cnt;
    assign o_cnt_en      = r_cnt_en;
    assign o_cnt_done    = r_cnt_done;
    assign o_cnt0        = w_cnt0;
    assign o_cnt1        = (W == W_WIDE) ? w_cnt0 : (r_cnt_en && (r_cnt == CNT_W'(1)));
    assign o_cnt2        = (W == W_WIDE) ? w_cnt0 : (r_cnt_en && (r_cnt == CNT_W'(2)));
    assign o_cnt3        = (W == W_WIDE) ? w_cnt0 : (r_cnt_en && (r_cnt == CNT_W'(3)));
    assign o_cnt7        = r_cnt_en && (r_cnt == BEAT7);
    assign o_cnt0to3     = r_cnt_en && (r_cnt < CNT_W'(4));
    assign o_cnt12to31   = r_cnt_en && (r_cnt >= CNT_W'(12));
    assign o_mem_bytecnt = r_cnt[4:3];

endmodule

// File: rtl/serv_state_w.sv
// Instruction sequencing for the serial core: init/run stages, optional MDU wait,
// trap capture and the ibus/dbus/RF request handshakes.
module serv_state_w
    import serv_pkg::*;
#(
    parameter int W     = 1,
    parameter int MDU   = 0,
    parameter int ALIGN = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rf_ready,
    input  logic             i_ibus_ack,
    input  logic             i_dbus_ack,
    input  logic             i_two_stage_op,
    input  logic             i_branch_op,
    input  logic             i_cond_branch,
    input  logic             i_bne_or_bge,
    input  logic             i_shift_op,
    input  logic             i_sh_right,
    input  logic             i_slt_or_branch,
    input  logic             i_dbus_en,
    input  logic             i_e_op,
    input  logic             i_rd_op,
    input  logic             i_mdu_op,
    input  logic             i_alu_cmp,
    input  logic             i_sh_done,
    input  logic             i_ctrl_misalign,
    input  logic             i_mem_misalign,
    input  logic             i_new_irq,
    input  logic             i_mdu_ready,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt_en,
    output logic             o_cnt_done,
    output logic             o_init,
    output logic             o_cnt0,
    output logic             o_cnt1,
    output logic             o_cnt2,
    output logic             o_cnt3,
    output logic             o_cnt7,
    output logic             o_cnt0to3,
    output logic             o_cnt12to31,
    output logic [1:0]       o_mem_bytecnt,
    output logic             o_ctrl_pc_en,
    output logic             o_ctrl_jump,
    output logic             o_ctrl_trap,
    output logic             o_bufreg_en,
    output logic             o_rf_rd_en,
    output logic             o_ibus_cyc,
    output logic             o_dbus_cyc,
    output logic             o_rf_rreq,
    output logic             o_rf_wreq,
    output logic             o_mdu_valid
);

    localparam bit HAS_MDU    = (MDU != 0);
    localparam bit CTRL_ALIGN = (ALIGN == 0);

    logic r_init_done;
    logic r_ctrl_jump;
    logic r_misalign_trap;
    logic r_stage_two_req;
    logic r_mdu_wait;
    logic r_ibus_cyc;
    logic w_take_branch;

    serv_state_cnt #(.W(W)) u_cnt (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_rf_ready    (i_rf_ready),
        .o_cnt         (o_cnt),
        .o_cnt_en      (o_cnt_en),
        .o_cnt_done    (o_cnt_done),
        .o_cnt0        (o_cnt0),
        .o_cnt1        (o_cnt1),
        .o_cnt2        (o_cnt2),
        .o_cnt3        (o_cnt3),
        .o_cnt7        (o_cnt7),
        .o_cnt0to3     (o_cnt0to3),
        .o_cnt12to31   (o_cnt12to31),
        .o_mem_bytecnt (o_mem_bytecnt)
    );

    assign w_take_branch = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
    assign o_init        = i_two_stage_op & !i_new_irq & !r_init_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_init_done     <= 1'b0;
            r_ctrl_jump     <= 1'b0;
            r_misalign_trap <= 1'b0;
            r_stage_two_req <= 1'b0;
            r_mdu_wait      <= 1'b0;
            r_ibus_cyc      <= 1'b1;
        end else begin
            if (o_cnt_done) begin
                r_init_done     <= o_init & !r_init_done;
                r_ctrl_jump     <= o_init & w_take_branch;
                r_stage_two_req <= o_init;
            end
            r_misalign_trap <= o_init & ((w_take_branch & i_ctrl_misalign & CTRL_ALIGN) |
                                         (i_dbus_en & i_mem_misalign));
            // A ready in the same cycle as the request completes it outright.
            r_mdu_wait <= HAS_MDU & !i_mdu_ready & (r_mdu_wait | o_mdu_valid);
            if (i_ibus_ack | o_cnt_done)
                r_ibus_cyc <= o_ctrl_pc_en;
        end
    end

    assign o_mdu_valid  = HAS_MDU & r_init_done & !o_cnt_en & i_mdu_op & !r_mdu_wait;
    assign o_ctrl_jump  = r_ctrl_jump;
    assign o_ctrl_trap  = i_e_op | i_new_irq | r_misalign_trap;
    assign o_ctrl_pc_en = o_cnt_en & !o_init;
    assign o_rf_rd_en   = i_rd_op & !o_init;
    assign o_ibus_cyc   = r_ibus_cyc & i_rst_n;
    assign o_dbus_cyc   = !o_cnt_en & r_init_done & i_dbus_en & !i_mem_misalign;
    assign o_rf_rreq    = i_ibus_ack | (r_stage_two_req & r_misalign_trap);
    assign o_rf_wreq    = !r_misalign_trap & !o_cnt_en & r_init_done &
                          ((i_shift_op & (i_sh_done | !i_sh_right)) | i_dbus_ack |
                           i_slt_or_branch | (i_mdu_op & i_mdu_ready));
    assign o_bufreg_en  = (o_cnt_en & (o_init | ((o_ctrl_trap | i_branch_op) & i_two_stage_op))) |
                          (i_shift_op & !r_stage_two_req & r_init_done & (i_sh_right | i_sh_done));

endmodule

// File: tb/tb_serv_state_w.sv
// Bench for serv_state_w: four instances (W=1, W=4, W=1+MDU, W=1+ALIGN) share stimulus.
module tb_serv_state_w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rf_ready, ibus_ack, dbus_ack, two_stage, branch_op, cond_branch, bne_or_bge;
    logic shift_op, sh_right, slt_or_branch, dbus_en, e_op, rd_op, mdu_op, alu_cmp, sh_done;
    logic ctrl_misalign, mem_misalign, new_irq, mdu_ready;

    logic [4:0] cnt_o [4];
    logic [1:0] bytecnt_o [4];
    logic [3:0] cnt_en_o, done_o, init_o, cnt0_o, cnt1_o, cnt2_o, cnt3_o, cnt7_o, c03_o, c1231_o;
    logic [3:0] pc_en_o, jump_o, trap_o, bufreg_o, rd_en_o, ibus_o, dbus_o, rreq_o, wreq_o, mdu_o;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        serv_state_w #(.W(g == 1 ? 4 : 1), .MDU(g == 2 ? 1 : 0), .ALIGN(g == 3 ? 1 : 0)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_rf_ready(rf_ready), .i_ibus_ack(ibus_ack),
            .i_dbus_ack(dbus_ack), .i_two_stage_op(two_stage), .i_branch_op(branch_op),
            .i_cond_branch(cond_branch), .i_bne_or_bge(bne_or_bge), .i_shift_op(shift_op),
            .i_sh_right(sh_right), .i_slt_or_branch(slt_or_branch), .i_dbus_en(dbus_en),
            .i_e_op(e_op), .i_rd_op(rd_op), .i_mdu_op(mdu_op), .i_alu_cmp(alu_cmp),
            .i_sh_done(sh_done), .i_ctrl_misalign(ctrl_misalign), .i_mem_misalign(mem_misalign),
            .i_new_irq(new_irq), .i_mdu_ready(mdu_ready),
            .o_cnt(cnt_o[g]), .o_cnt_en(cnt_en_o[g]), .o_cnt_done(done_o[g]), .o_init(init_o[g]),
            .o_cnt0(cnt0_o[g]), .o_cnt1(cnt1_o[g]), .o_cnt2(cnt2_o[g]), .o_cnt3(cnt3_o[g]),
            .o_cnt7(cnt7_o[g]), .o_cnt0to3(c03_o[g]), .o_cnt12to31(c1231_o[g]),
            .o_mem_bytecnt(bytecnt_o[g]), .o_ctrl_pc_en(pc_en_o[g]), .o_ctrl_jump(jump_o[g]),
            .o_ctrl_trap(trap_o[g]), .o_bufreg_en(bufreg_o[g]), .o_rf_rd_en(rd_en_o[g]),
            .o_ibus_cyc(ibus_o[g]), .o_dbus_cyc(dbus_o[g]), .o_rf_rreq(rreq_o[g]),
            .o_rf_wreq(wreq_o[g]), .o_mdu_valid(mdu_o[g])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {rf_ready, ibus_ack, dbus_ack, two_stage, branch_op, cond_branch, bne_or_bge} = '0;
        {shift_op, sh_right, slt_or_branch, dbus_en, e_op, rd_op, mdu_op, alu_cmp, sh_done} = '0;
        {ctrl_misalign, mem_misalign, new_irq, mdu_ready} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic run_to_done(input int idx);
        bit hit = 1'b0;
        rf_ready = 1'b1;
        step();
        rf_ready = 1'b0;
        for (int n = 0; n < 64 && !hit; n++) begin
            if (done_o[idx]) hit = 1'b1;
            else step();
        end
        chk("done_reached", 32'(hit), 32'd1);
    endtask

    typedef struct {
        logic two_stage, new_irq, e_op, rd_op;
        logic exp_init, exp_rd_en, exp_trap;
    } idle_vec_t;

    typedef struct {
        logic [4:0] cnt;
        logic [7:0] dec;  // {cnt0,cnt1,cnt2,cnt3,cnt7,cnt0to3,cnt12to31,done}
    } beat_vec_t;

    idle_vec_t iv [8];
    beat_vec_t bv [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n1, ndone;
        bit seen, post_done;
        logic [4:0] done_cnt;

        iv[0] = '{0,0,0,0, 0,0,0};
        iv[1] = '{1,0,0,0, 1,0,0};
        iv[2] = '{1,1,0,0, 0,0,1};
        iv[3] = '{0,0,1,1, 0,1,1};
        iv[4] = '{1,0,0,1, 1,0,0};
        iv[5] = '{1,1,0,1, 0,1,1};
        iv[6] = '{0,1,0,0, 0,0,1};
        iv[7] = '{0,0,0,1, 0,1,0};

        bv[0] = '{5'd0,  8'b1111_0100};
        bv[1] = '{5'd4,  8'b0000_1000};
        bv[2] = '{5'd8,  8'b0000_0000};
        bv[3] = '{5'd12, 8'b0000_0010};
        bv[4] = '{5'd16, 8'b0000_0010};
        bv[5] = '{5'd20, 8'b0000_0010};
        bv[6] = '{5'd24, 8'b0000_0010};
        bv[7] = '{5'd28, 8'b0000_0011};

        // Reset state, including ibus_cyc forced low while held in reset.
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_ibus_forced", 32'(ibus_o), 32'h0);
        chk("rst_cnt", 32'(cnt_o[0]), 32'd0);
        chk("rst_cnt_en", 32'(cnt_en_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_jump", 32'(jump_o), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_ibus", 32'(ibus_o), 32'hf);

        for (int i = 0; i < 8; i++) begin
            two_stage = iv[i].two_stage; new_irq = iv[i].new_irq;
            e_op = iv[i].e_op; rd_op = iv[i].rd_op;
            #1;
            chk($sformatf("idle_init[%0d]", i), 32'(init_o[0]), 32'(iv[i].exp_init));
            chk($sformatf("idle_rd_en[%0d]", i), 32'(rd_en_o[0]), 32'(iv[i].exp_rd_en));
            chk($sformatf("idle_trap[%0d]", i), 32'(trap_o[0]), 32'(iv[i].exp_trap));
            chk($sformatf("idle_pc_buf[%0d]", i), 32'({pc_en_o[0], bufreg_o[0]}), 32'h0);
        end
        clear_inputs();

        // ADD: fetch ack drops ibus_cyc, then one phase on W=1 and W=4 together.
        ibus_ack = 1'b1;
        #1;
        chk("ack_rreq", 32'(rreq_o[0]), 32'd1);
        step();
        ibus_ack = 1'b0;
        #1;
        chk("ack_ibus_low", 32'(ibus_o[0]), 32'd0);
        rf_ready = 1'b1;
        step();
        rf_ready = 1'b0;
        n0 = 0; n1 = 0; ndone = 0; seen = 0; post_done = 0; done_cnt = '1;
        for (int i = 0; i < 40; i++) begin
            if (seen && !post_done) begin
                chk("add_ibus_after_done", 32'({ibus_o[0], cnt_en_o[0]}), 32'b10);
                post_done = 1'b1;
            end
            if (cnt_en_o[0]) begin
                n0++;
                if (!seen) chk("add_ibus_during", 32'(ibus_o[0]), 32'd0);
            end
            if (done_o[0]) begin
                ndone++;
                done_cnt = cnt_o[0];
                seen = 1'b1;
            end
            if (cnt_en_o[1]) begin
                if (n1 < 8)
                    chk($sformatf("w4_beat[%0d]", n1),
                        32'({cnt_o[1], cnt0_o[1], cnt1_o[1], cnt2_o[1], cnt3_o[1], cnt7_o[1],
                             c03_o[1], c1231_o[1], done_o[1]}),
                        32'({bv[n1].cnt, bv[n1].dec}));
                n1++;
            end
            step();
        end
        chk("w1_beats", 32'(n0), 32'd32);
        chk("w4_beats", 32'(n1), 32'd8);
        chk("w1_done_pulses", 32'(ndone), 32'd1);
        chk("w1_done_cnt", 32'(done_cnt), 32'd31);
        chk("w4_ibus_after", 32'(ibus_o[1]), 32'd1);
        chk("wrap_cnt", 32'({cnt_o[0], cnt_o[1]}), 32'h0);

        // BEQ taken with a misaligned target: ALIGN=0 traps, ALIGN=1 does not.
        do_reset();
        two_stage = 1; branch_op = 1; cond_branch = 1; alu_cmp = 1; bne_or_bge = 0;
        ctrl_misalign = 1; slt_or_branch = 1;
        run_to_done(0);
        chk("beq_init_at_done", 32'(init_o[0]), 32'd1);
        step();
        chk("beq_jump", 32'({jump_o[0], jump_o[3]}), 32'b11);
        chk("beq_trap", 32'({trap_o[0], trap_o[3]}), 32'b10);
        chk("beq_rreq", 32'({rreq_o[0], rreq_o[3]}), 32'b10);
        chk("beq_wreq", 32'({wreq_o[0], wreq_o[3]}), 32'b01);
        step();
        chk("beq_rreq_once", 32'(rreq_o[0]), 32'd0);

        // Load: dbus_cyc held until ack, write request only with the ack.
        do_reset();
        two_stage = 1; dbus_en = 1; rd_op = 1;
        run_to_done(0);
        step();
        n0 = 0;
        for (int i = 0; i < 5; i++) begin
            if (!dbus_o[0] || wreq_o[0]) n0++;
            step();
        end
        chk("load_wait_cycles", 32'(n0), 32'd0);
        dbus_ack = 1'b1;
        #1;
        chk("load_ack", 32'({dbus_o[0], wreq_o[0], rd_en_o[0]}), 32'b111);

        // MUL: single valid pulse, result written only when ready arrives.
        do_reset();
        two_stage = 1; mdu_op = 1;
        run_to_done(2);
        step();
        chk("mdu_off_valid", 32'(mdu_o[0]), 32'd0);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            if (mdu_o[2]) n0++;
            if (wreq_o[2]) n1++;
            step();
        end
        chk("mdu_valid_pulses", 32'(n0), 32'd1);
        chk("mdu_wreq_early", 32'(n1), 32'd0);
        mdu_ready = 1'b1;
        #1;
        chk("mdu_ready_wreq", 32'({mdu_o[2], wreq_o[2]}), 32'b01);

        // Ready in the same cycle as valid completes the handshake.
        do_reset();
        two_stage = 1; mdu_op = 1;
        run_to_done(2);
        step();
        mdu_ready = 1'b1;
        rf_ready = 1'b1;
        #1;
        chk("mdu_same_cycle", 32'({mdu_o[2], wreq_o[2]}), 32'b11);
        step();
        mdu_ready = 1'b0;
        rf_ready = 1'b0;
        #1;
        chk("mdu_same_next", 32'({cnt_en_o[2], mdu_o[2]}), 32'b10);
        chk("mdu_wait_clear", 32'(gen_dut[2].u_dut.r_mdu_wait), 32'd0);

        // Reset in the middle of stage two aborts sequencing.
        do_reset();
        two_stage = 1;
        run_to_done(0);
        step();
        rf_ready = 1'b1;
        step();
        rf_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (cnt_o[0] == 5'd16) seen = 1'b1;
            else step();
        end
        chk("mid_reached16", 32'(seen), 32'd1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_state", 32'({cnt_o[0], cnt_en_o[0], done_o[0], jump_o[0], ibus_o[0]}), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("mid_rel", 32'({ibus_o[0], init_o[0]}), 32'b11);
        step();
        chk("mid_after", 32'({ibus_o[0], cnt_en_o[0]}), 32'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
